// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue_pkg
//  Description : Shared constants for the instruction-fetch queue block.
//                Constants only: reset PC default, instruction width and the
//                PC increment applied per fetched word.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_queue_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  // Instruction word width.
  localparam int unsigned C_INST_W = 32;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] C_PC_INC = 32'd4;

endpackage : if_fetch_queue_pkg
`default_nettype wire

// File: rtl/if_fetch_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue_sync_fifo
//  Description : Single-clock FIFO with occupancy count and synchronous
//                flush. The head is read straight out of the storage array, so
//                a word written on a clock edge is visible only after that
//                edge (no combinational write-to-head bypass).
//                Push while full is accepted only together with a pop.
//  Ports       :
//    clk          in   clock, rising edge
//    reset        in   asynchronous, active-low reset
//    i_flush      in   empty the FIFO on the next edge (overrides push/pop)
//    i_push       in   write i_push_data at the tail
//    i_push_data  in   WIDTH-bit tail data
//    i_pop        in   drop the head entry (ignored when empty)
//    o_head       out  head entry (meaningful only when o_count != 0)
//    o_count      out  occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4     // power of 2, at least 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned   AW          = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL_CNT  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop & (r_count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ((r_count != C_FULL_CNT) | w_do_pop);

  // Storage carries no reset; consumers qualify the head with o_count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : if_fetch_queue_sync_fifo
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue
//  Description : Instruction-fetch front end feeding the IF/ID register.
//                Owns the fetch PC, issues in-order word requests to a
//                valid/ready instruction memory, buffers returned words with
//                their PC+4 and presents the head to IF/ID. A stall holds the
//                head; a redirect flushes the buffer, turns every in-flight
//                request into a discard credit and restarts at the target.
//  Ports       :
//    clk            in   clock, rising edge
//    reset          in   asynchronous, active-low reset
//    mem_req_valid  out  fetch request valid
//    mem_req_ready  in   memory accepts the request
//    mem_req_addr   out  byte address of the requested word (= fetch PC)
//    mem_rsp_valid  in   response word valid (in request order)
//    mem_rsp_data   in   instruction word
//    redirect       in   branch taken, restart fetch at redirect_pc
//    redirect_pc    in   new fetch address
//    stall          in   IF/ID stall, hold the head entry
//    inst_valid     out  head entry valid
//    inst           out  head instruction (0 when not valid)
//    inst_pc_plus4  out  PC+4 of the head instruction (0 when not valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,          // power of 2, at least 2
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [C_INST_W-1:0] mem_rsp_data,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  output logic                inst_valid,
  output logic [C_INST_W-1:0] inst,
  output logic [31:0]         inst_pc_plus4
);

  // CW holds 0..DEPTH; the extra bit on the sum avoids wrap in the credit test.
  localparam int unsigned   CW          = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   C_DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] C_DEPTH_CNT = CW'(DEPTH);
  localparam int unsigned   C_ENTRY_W   = C_INST_W + 32;

  logic [31:0]          r_fetch_pc;
  logic [CW-1:0]        r_live;       // accepted, response will be kept
  logic [CW-1:0]        r_drop;       // accepted, response will be discarded

  logic [CW-1:0]        w_live_nxt;
  logic [CW-1:0]        w_drop_nxt;
  logic                 w_credit_ok;
  logic                 w_hs;
  logic                 w_rsp_take;   // response consumes an outstanding slot
  logic                 w_rsp_keep;   // response is written into the buffer
  logic                 w_pop;

  logic [31:0]          w_pcq_head;   // PC+4 of the oldest outstanding request
  logic [CW-1:0]        w_pcq_count;
  logic [C_ENTRY_W-1:0] w_rf_head;
  logic [CW-1:0]        w_rf_count;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // The PC queue holds exactly one entry per outstanding request, so its
  // occupancy equals live + drop and bounds the number in flight. Counting
  // live requests against buffer space guarantees every kept word has a slot.
  assign w_credit_ok   = (({1'b0, w_rf_count} + {1'b0, r_live}) < C_DEPTH_SUM)
                       && (w_pcq_count < C_DEPTH_CNT);
  assign mem_req_valid = reset & w_credit_ok;
  assign mem_req_addr  = r_fetch_pc;
  assign w_hs          = mem_req_valid & mem_req_ready;

  // --------------------------------------------------------------------------
  // Response side
  // --------------------------------------------------------------------------
  // A response arriving with nothing outstanding is ignored entirely.
  // Discards are always older than kept requests (a redirect converts the
  // whole in-flight set), so drop is drained first.
  assign w_rsp_take = mem_rsp_valid & ((r_live != '0) | (r_drop != '0));
  assign w_rsp_keep = mem_rsp_valid & (r_drop == '0) & (r_live != '0) & ~redirect;
  assign w_pop      = (w_rf_count != '0) & ~stall & ~redirect;

  always_comb begin
    w_live_nxt = r_live;
    w_drop_nxt = r_drop;
    if (redirect) begin
      // Everything in flight, including a request accepted right now, becomes
      // stale; a response in this same cycle is already one of those.
      w_live_nxt = '0;
      w_drop_nxt = r_drop + r_live + CW'(w_hs) - CW'(w_rsp_take);
    end else begin
      if (w_hs) begin
        w_live_nxt = w_live_nxt + CW'(1);
      end
      if (mem_rsp_valid) begin
        if (r_drop != '0) begin
          w_drop_nxt = r_drop - CW'(1);
        end else if (r_live != '0) begin
          w_live_nxt = w_live_nxt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
    end else begin
      r_live <= w_live_nxt;
      r_drop <= w_drop_nxt;
      // An unaccepted request is simply replaced by the redirect target.
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + C_PC_INC;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request-PC tracking queue: pushed on acceptance, popped on every consumed
  // response (kept or discarded). Never flushed, so stale entries stay aligned
  // with the stale responses still to come back.
  // --------------------------------------------------------------------------
  if_fetch_queue_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (1'b0),
    .i_push      (w_hs),
    .i_push_data (r_fetch_pc + C_PC_INC),
    .i_pop       (w_rsp_take),
    .o_head      (w_pcq_head),
    .o_count     (w_pcq_count)
  );

  // --------------------------------------------------------------------------
  // Response buffer {inst, pc+4}; a redirect empties it on the next edge.
  // --------------------------------------------------------------------------
  if_fetch_queue_sync_fifo #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (redirect),
    .i_push      (w_rsp_keep),
    .i_push_data ({mem_rsp_data, w_pcq_head}),
    .i_pop       (w_pop),
    .o_head      (w_rf_head),
    .o_count     (w_rf_count)
  );

  // --------------------------------------------------------------------------
  // IF/ID side: outputs read zero whenever the head is not valid.
  // --------------------------------------------------------------------------
  assign inst_valid    = (w_rf_count != '0);
  assign inst          = inst_valid ? w_rf_head[C_ENTRY_W-1:32] : '0;
  assign inst_pc_plus4 = inst_valid ? w_rf_head[31:0]           : '0;

endmodule : if_fetch_queue
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_queue
//  Description : Self-checking bench for if_fetch_queue. A table of per-cycle
//                expectations covers start-up and stall back-pressure, short
//                hand sequences cover redirect corner cases, PC wrap and
//                asynchronous reset, and a randomized phase is compared every
//                cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'h1357_9BDF;  // directed data = addr ^ KEY

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc_plus4;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: accepted requests waiting to return, in order.
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc       = 0;
  int    lat_min   = 1;
  int    lat_max   = 1;
  int    gap_pct   = 0;
  bit    rand_data = 1'b0;

  // Reference model: outstanding requests (keep flag) and buffered entries.
  typedef struct { logic [31:0] pcp4; bit keep; } oreq_t;
  typedef struct { logic [31:0] inst; logic [31:0] pcp4; } ent_t;
  oreq_t       oq[$];
  ent_t        bq[$];
  logic [31:0] m_pc;

  typedef struct packed {
    bit          stall;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pcp4;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int kept;
    bit exp_rv;
    kept = 0;
    foreach (oq[i]) if (oq[i].keep) kept++;
    exp_rv = (reset === 1'b1) && ((bq.size() + kept) < DEPTH) && (oq.size() < DEPTH);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
    chk("req_addr", mem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(bq.size() > 0));
    if (bq.size() > 0) begin
      chk("inst", inst, bq[0].inst);
      chk("inst_pc_plus4", inst_pc_plus4, bq[0].pcp4);
    end else begin
      chk("inst_idle", inst, 32'h0);
      chk("inst_pc_plus4_idle", inst_pc_plus4, 32'h0);
    end
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99, 0) >= gap_pct) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mq[0].data;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom();
    end
  endtask

  // One clock cycle: check at the falling edge, advance the model with the
  // inputs seen there, then update the memory model just after the rising edge.
  task automatic tick(input bit use_exp, input vec_t v);
    bit          s_hs, s_rsp, s_redir, s_stall;
    logic [31:0] s_addr, s_data, s_rpc;
    oreq_t       r;
    ent_t        e;
    mreq_t       q;
    @(negedge clk);
    check_model();
    if (use_exp) begin
      chk("tbl_req_valid", 32'(mem_req_valid), 32'(v.rv));
      chk("tbl_req_addr", mem_req_addr, v.addr);
      chk("tbl_inst_valid", 32'(inst_valid), 32'(v.iv));
      chk("tbl_pc_plus4", inst_pc_plus4, v.pcp4);
      chk("tbl_inst", inst, v.iv ? ((v.pcp4 - 32'd4) ^ KEY) : 32'h0);
    end
    s_hs    = mem_req_valid && mem_req_ready;
    s_addr  = mem_req_addr;
    s_rsp   = mem_rsp_valid;
    s_data  = mem_rsp_data;
    s_redir = redirect;
    s_rpc   = redirect_pc;
    s_stall = stall;

    if (bq.size() > 0 && !s_stall && !s_redir) bq.delete(0);
    if (s_rsp) begin
      checks++;
      if (oq.size() == 0) begin
        errors++;
        $display("FAIL protocol response with no request outstanding (t=%0t)", $time);
      end else begin
        r = oq[0];
        oq.delete(0);
        if (r.keep && !s_redir) begin
          e.inst = s_data;
          e.pcp4 = r.pcp4;
          bq.push_back(e);
        end
      end
    end
    if (s_redir) begin
      foreach (oq[i]) oq[i].keep = 1'b0;
      bq.delete();
    end
    if (s_hs) begin
      r.pcp4 = m_pc + 32'd4;
      r.keep = !s_redir;
      oq.push_back(r);
    end
    if (s_redir)   m_pc = s_rpc;
    else if (s_hs) m_pc = m_pc + 32'd4;

    @(posedge clk);
    #1;
    cyc++;
    if (s_rsp && mq.size() > 0) mq.delete(0);
    if (s_hs) begin
      q.addr = s_addr;
      q.data = rand_data ? $urandom() : (s_addr ^ KEY);
      q.due  = cyc + $urandom_range(lat_max, lat_min) - 1;
      mq.push_back(q);
    end
    drive_rsp();
  endtask

  task automatic step();
    tick(1'b0, '0);
  endtask

  // Asserts reset immediately (may be mid-cycle), checks the asynchronous
  // clear, then releases just after a rising edge.
  task automatic do_reset();
    reset         = 1'b0;
    redirect      = 1'b0;
    stall         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mq.delete();
    oq.delete();
    bq.delete();
    m_pc = 32'h0;
    #1;
    check_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_iv(input string name, input int budget);
    int n;
    n = 0;
    while (!inst_valid && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 32'(inst_valid), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    stall         = 1'b0;
    m_pc          = 32'h0;

    // Start-up under stall, then release: {stall, req_valid, addr, iv, pc+4}
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h04};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h04};
    tbl[10] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h04};
    tbl[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[12] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[13] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[14] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[15] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};

    @(posedge clk);
    #1;
    do_reset();

    // ---- table: start-up, stall fills DEPTH entries, drain, steady state
    mem_req_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall;
      tick(1'b1, tbl[i]);
    end

    // ---- latency 3, two outstanding, redirect to 0x100
    do_reset();
    lat_min = 3; lat_max = 3;
    mem_req_ready = 1'b1;
    step();
    step();
    mem_req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0; mem_req_ready = 1'b1;
    wait_iv("b_first", 20);
    chk("b_pc_plus4", inst_pc_plus4, 32'h104);
    chk("b_inst", inst, 32'h100 ^ KEY);

    // ---- redirect with a response and a handshake in the same cycle
    do_reset();
    lat_min = 1; lat_max = 1;
    mem_req_ready = 1'b1;
    step();
    chk("c_req_valid", 32'(mem_req_valid), 32'h1);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    wait_iv("c_first", 20);
    chk("c_pc_plus4", inst_pc_plus4, 32'h104);
    chk("c_inst", inst, 32'h100 ^ KEY);

    // ---- ready low for 5 cycles holds the address; redirect replaces it
    do_reset();
    mem_req_ready = 1'b1;
    step();
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("d_addr_hold", mem_req_addr, 32'h8);
      chk("d_valid_hold", 32'(mem_req_valid), 32'h1);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("d_addr_redirect", mem_req_addr, 32'h200);

    // ---- PC wrap at the top of the address space
    mem_req_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("e_addr_top", mem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("e_addr_wrap", mem_req_addr, 32'h0);
    wait_iv("e_first", 20);
    chk("e_pc_plus4", inst_pc_plus4, 32'h0);
    chk("e_inst", inst, 32'hFFFF_FFFC ^ KEY);

    // ---- reset asserted mid-burst (checked asynchronously inside do_reset)
    repeat (4) step();
    chk("f_busy", 32'(inst_valid), 32'h1);
    #3;
    do_reset();

    // ---- randomized traffic against the reference model
    rand_data = 1'b1;
    lat_min = 1; lat_max = 4; gap_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      mem_req_ready = ($urandom_range(99, 0) < 75);
      stall         = ($urandom_range(99, 0) < 30);
      redirect      = ($urandom_range(99, 0) < 6);
      redirect_pc   = ($urandom_range(99, 0) < 10) ? 32'hFFFF_FFF0
                                                   : ($urandom() & 32'hFFFF_FFFC);
      step();
      if (i == 1500) begin
        #3;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_if_fetch_queue
`default_nettype wire
